// File: rtl/sm83_regfile_pkg.sv
// Shared constants for the SM83 register file: register indices, flag bit
// positions and write-port mode encodings.
package sm83_regfile_pkg;

  localparam int REG_B   = 0;
  localparam int REG_C   = 1;
  localparam int REG_D   = 2;
  localparam int REG_E   = 3;
  localparam int REG_H   = 4;
  localparam int REG_L   = 5;
  localparam int REG_SPH = 6;
  localparam int REG_SPL = 7;
  localparam int REG_PCH = 8;
  localparam int REG_PCL = 9;
  localparam int REG_A   = 10;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_BYTE = 2'b01,
    WR_RSVD = 2'b10,
    WR_PAIR = 2'b11
  } wr_mode_e;

endpackage

// File: rtl/sm83_regfile_if.sv
// Bus bundle between the register file (slave) and its user (master):
// write port, IDU request, flag write and the packed read ports.
interface sm83_regfile_if #(
  parameter int NUM_PAIRS = 6,
  parameter int NUM_RD    = 2
);
  localparam int IDX_W = $clog2(2 * NUM_PAIRS);

  logic [1:0]              wr_en;
  logic [IDX_W-1:0]        wr_reg;
  logic [15:0]             wr_data;
  logic                    idu_en;
  logic [IDX_W-2:0]        idu_pair;
  logic                    idu_dec;
  logic                    flag_we;
  logic [3:0]              flag_mask;
  logic [7:0]              flag_data;
  logic [NUM_RD*IDX_W-1:0] rd_reg;
  logic [NUM_RD*8-1:0]     rd_data;
  logic [NUM_RD*8-1:0]     rd_data_lo;
  logic [NUM_RD*16-1:0]    rd_pair;
  logic [7:0]              rd_flag;

  modport master (
    output wr_en, wr_reg, wr_data, idu_en, idu_pair, idu_dec,
           flag_we, flag_mask, flag_data, rd_reg,
    input  rd_data, rd_data_lo, rd_pair, rd_flag
  );

  modport slave (
    input  wr_en, wr_reg, wr_data, idu_en, idu_pair, idu_dec,
           flag_we, flag_mask, flag_data, rd_reg,
    output rd_data, rd_data_lo, rd_pair, rd_flag
  );

endinterface

// File: rtl/sm83_idu.sv
// 16-bit combinational increment/decrement unit; wraps modulo 2^16.
module sm83_idu (
  input  logic [15:0] i_value,
  input  logic        i_dec,
  output logic [15:0] o_result
);

  assign o_result = i_dec ? (i_value - 16'd1) : (i_value + 16'd1);

endmodule

// File: rtl/sm83_regfile_p.sv
// SM83 byte/pair register file with IDU and flags. Define
// SM83_REGFILE_BYPASS_EN to forward same-cycle updates to the read ports.
module sm83_regfile_p
  import sm83_regfile_pkg::*;
#(
  parameter int NUM_PAIRS = 6,
  parameter int NUM_RD    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sm83_regfile_if.slave  rf
);

  localparam int IDX_W    = $clog2(2 * NUM_PAIRS);
  localparam int PAIR_W   = IDX_W - 1;
  localparam int NUM_REGS = 2 * NUM_PAIRS;

  logic [7:0]  r_regs    [NUM_REGS];
  logic [7:0]  w_next    [NUM_REGS];
  logic [7:0]  w_src     [NUM_REGS];
  logic [3:0]  r_flags;
  logic [3:0]  w_nextFlags;
  logic [3:0]  w_srcFlags;
  logic [15:0] w_iduIn;
  logic [15:0] w_iduOut;

  always_comb begin
    w_iduIn = '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (rf.idu_pair == PAIR_W'(p)) w_iduIn = {r_regs[2*p], r_regs[2*p+1]};
    end
  end

  sm83_idu u_idu (
    .i_value  (w_iduIn),
    .i_dec    (rf.idu_dec),
    .o_result (w_iduOut)
  );

  // IDU result first, then the write port overrides whichever bytes it touches.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_next[i] = r_regs[i];
      if (rf.idu_en && rf.idu_pair == PAIR_W'(i / 2))
        w_next[i] = (i % 2 == 1) ? w_iduOut[7:0] : w_iduOut[15:8];
      if (rf.wr_en == WR_BYTE && rf.wr_reg == IDX_W'(i))
        w_next[i] = rf.wr_data[7:0];
      if (rf.wr_en == WR_PAIR && rf.wr_reg[IDX_W-1:1] == PAIR_W'(i / 2))
        w_next[i] = (i % 2 == 1) ? rf.wr_data[7:0] : rf.wr_data[15:8];
    end
    for (int k = 0; k < 4; k++) begin
      w_nextFlags[k] = (rf.flag_we && rf.flag_mask[k]) ? rf.flag_data[FLAG_C+k]
                                                         : r_flags[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_flags <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= w_next[i];
      r_flags <= w_nextFlags;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef SM83_REGFILE_BYPASS_EN
      w_src[i] = rst_n ? w_next[i] : 8'h00;
`else
      w_src[i] = r_regs[i];
`endif
    end
`ifdef SM83_REGFILE_BYPASS_EN
    w_srcFlags = rst_n ? w_nextFlags : 4'h0;
`else
    w_srcFlags = r_flags;
`endif
  end

  // Indices with no matching register fall through to zero.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_idxLo;
    logic [7:0]       w_hi;
    logic [7:0]       w_lo;

    assign w_idx   = rf.rd_reg[k*IDX_W +: IDX_W];
    assign w_idxLo = w_idx | IDX_W'(1);

    always_comb begin
      w_hi = 8'h00;
      w_lo = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_idx == IDX_W'(i))   w_hi = w_src[i];
        if (w_idxLo == IDX_W'(i)) w_lo = w_src[i];
      end
    end

    assign rf.rd_data[k*8 +: 8]    = w_hi;
    assign rf.rd_data_lo[k*8 +: 8] = w_lo;
    assign rf.rd_pair[k*16 +: 16]  = {w_hi, w_lo};
  end

  assign rf.rd_flag = {w_srcFlags, 4'b0000};

endmodule
